instr_fetch: RTL and testbench

Instruction fetch stage directly upstream of the instruction decoder. Owns the fetch PC, issues 16-bit word reads to instruction memory over a request/grant/response interface, buffers returned words with their addresses in a small FIFO, and presents one instruction at a time to the decoder through a valid/ready handshake. A redirect input (taken branch or jmp from execute) flushes buffered and in-flight fetches and restarts at the new target.

---
 rtl/nqcpu_pkg.sv | 10 +
 rtl/fetch_fifo.sv | 47 ++++
 rtl/instr_fetch.sv | 79 +++++++
 tb/tb_instr_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/nqcpu_pkg.sv
// nqcpu_pkg: shared widths, NOP encoding, fetch entry layout and fetch FSM states
package nqcpu_pkg;
  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] NOP_INSTR = 16'hF000;
  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;
  typedef enum logic {BOOT, RUN} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: shift-style FIFO of fetched words; entry 0 is the head register.
// Slots at or beyond the new occupancy are never rewritten, so an empty FIFO keeps the last head pc.
module fetch_fifo
  import nqcpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic clear,
  input  fetch_entry_t data,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output fetch_entry_t head
);
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t ent_q [DEPTH];
  fetch_entry_t ent_d [DEPTH];
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] base;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign base = count - CW'(do_pop);
  assign head = '{pc: ent_q[0].pc, instr: empty ? NOP_INSTR : ent_q[0].instr};
  always_comb begin
    cnt_d = clear ? '0 : base + CW'(push);
    for (int i = 0; i < DEPTH; i++)
      ent_d[i] = CW'(i) >= cnt_d ? ent_q[i] :
                 (push && CW'(i) == base) ? data :
                 do_pop ? ent_q[(i + 1) % DEPTH] : ent_q[i];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '{pc: RESET_PC, instr: NOP_INSTR};
    end else begin
      count <= cnt_d;
      ent_q <= ent_d;
    end
  end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch PC, credit-limited memory requests, response tagging and redirect flush.
// inflight + count never exceeds DEPTH, so a response always has a FIFO slot waiting for it.
module instr_fetch
  import nqcpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic mem_req,
  output logic [WORD_W-1:0] mem_addr,
  input  logic mem_gnt,
  input  logic mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] instr,
  output logic [WORD_W-1:0] instr_pc,
  output logic instr_valid,
  input  logic instr_ready,
  input  logic redirect,
  input  logic [WORD_W-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [WORD_W-1:0] PC0 = {RESET_PC[WORD_W-1:1], 1'b0};
  fetch_state_t state, state_d;
  logic [WORD_W-1:0] fetch_pc, tag_pc, target;
  logic [CW-1:0] inflight, discard, count;
  logic [CW:0] used;
  logic empty, fifo_full_unused, pop, gnt, push;
  fetch_entry_t head, wdata;
  assign target = {redirect_pc[WORD_W-1:1], 1'b0};
  assign used = {1'b0, inflight} + {1'b0, count};
  assign instr_valid = !empty;
  assign pop = instr_valid && instr_ready;
  assign gnt = mem_req && mem_gnt;
  assign push = mem_rvalid && discard == '0 && !redirect;
  assign mem_addr = fetch_pc;
  assign wdata = '{pc: tag_pc, instr: mem_rdata};
  assign instr = head.instr;
  assign instr_pc = head.pc;
  always_comb begin
    state_d = RUN;
    mem_req = state == RUN && !redirect &&
              (used < (CW+1)'(DEPTH) || (used == (CW+1)'(DEPTH) && pop));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      fetch_pc <= PC0;
      tag_pc <= PC0;
      inflight <= '0;
      discard <= '0;
    end else begin
      state <= state_d;
      inflight <= inflight + CW'(gnt) - CW'(mem_rvalid);
      if (redirect) begin
        discard <= inflight + CW'(gnt) - CW'(mem_rvalid);
        fetch_pc <= target;
        tag_pc <= target;
      end else begin
        if (gnt) fetch_pc <= fetch_pc + 16'd2;
        if (mem_rvalid && discard != '0) discard <= discard - CW'(1);
        if (push) tag_pc <= tag_pc + 16'd2;
      end
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .RESET_PC(PC0)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .clear(redirect),
    .data(wdata),
    .full(fifo_full_unused),
    .empty(empty),
    .count(count),
    .head(head)
  );
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed table plus redirect/backpressure/wrap/reset sequences and a random scoreboard run.
module tb_instr_fetch;
  import nqcpu_pkg::*;
  localparam logic [15:0] RPC = 16'h0100;
  logic clk = 1'b0, rst_n = 1'b1;
  logic mem_req, mem_gnt, mem_rvalid = 1'b0, instr_valid, instr_ready = 1'b0, redirect = 1'b0;
  logic [15:0] mem_addr, mem_rdata = 16'h0, instr, instr_pc, redirect_pc = 16'h0;
  logic gnt_en = 1'b1, gnt_rand = 1'b0, rv_rand = 1'b0, rv_hold = 1'b0;
  logic pend = 1'b0;
  logic [15:0] pend_addr = 16'h0, exp_pc = RPC;
  logic [15:0] q[$];
  int checks = 0, errors = 0, pops = 0;
  typedef struct {
    logic rdy;
    logic req;
    logic [15:0] addr;
    logic vld;
    logic [15:0] pc;
  } vec_t;
  vec_t tbl[13];

  always #5 clk = ~clk;
  assign mem_gnt = mem_req && gnt_en;

  instr_fetch #(.RESET_PC(RPC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h1234;
  endfunction

  // in-order memory: granted addresses queue up and answer no earlier than the next cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else begin
      if (mem_rvalid && q.size() > 0) void'(q.pop_front());
      if (mem_req && mem_gnt) q.push_back(mem_addr);
    end
  end
  always @(negedge clk) begin
    gnt_en = gnt_rand ? ($urandom_range(0, 1) == 0) : 1'b1;
    if (!rst_n || q.size() == 0 || rv_hold || (rv_rand && $urandom_range(0, 1) == 1)) begin
      mem_rvalid = 1'b0;
      mem_rdata = 16'hDEAD;
    end else begin
      mem_rvalid = 1'b1;
      mem_rdata = memf(q[0]);
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic score();
    if (pend && !redirect) begin
      chk("req_stable", 16'(mem_req), 16'd1);
      chk("addr_stable", mem_addr, pend_addr);
    end
    pend = mem_req && !mem_gnt;
    pend_addr = mem_addr;
    checks++;
    if (int'(dut.inflight) + int'(dut.u_fifo.count) > 2) begin
      errors++;
      $display("FAIL credit: inflight+count=%0d required <=2", int'(dut.inflight) + int'(dut.u_fifo.count));
    end
    checks++;
    if (dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop) begin
      errors++;
      $display("FAIL push_full: push into full FIFO without pop at %0t", $time);
    end
    if (instr_valid && instr_ready) begin
      chk("sb_pc", instr_pc, exp_pc);
      chk("sb_instr", instr, memf(instr_pc));
      exp_pc += 16'd2;
      pops++;
    end
    if (redirect) exp_pc = {redirect_pc[15:1], 1'b0};
  endtask

  task automatic tick(input logic rdy, input logic rd = 1'b0, input logic [15:0] rp = 16'h0);
    @(negedge clk);
    instr_ready = rdy;
    redirect = rd;
    redirect_pc = rp;
    #1;
    score();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 16'(mem_req), 16'd0);
    chk({tag, "_addr"}, mem_addr, RPC);
    chk({tag, "_valid"}, 16'(instr_valid), 16'd0);
    chk({tag, "_instr"}, instr, NOP_INSTR);
    chk({tag, "_pc"}, instr_pc, RPC);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 16'h0100, 1'b0, 16'h0100};
    tbl[1]  = '{1'b1, 1'b1, 16'h0100, 1'b0, 16'h0100};
    tbl[2]  = '{1'b1, 1'b1, 16'h0102, 1'b0, 16'h0100};
    tbl[3]  = '{1'b1, 1'b1, 16'h0104, 1'b1, 16'h0100};
    tbl[4]  = '{1'b1, 1'b1, 16'h0106, 1'b1, 16'h0102};
    tbl[5]  = '{1'b1, 1'b1, 16'h0108, 1'b1, 16'h0104};
    tbl[6]  = '{1'b0, 1'b0, 16'h010A, 1'b1, 16'h0106};
    tbl[7]  = '{1'b0, 1'b0, 16'h010A, 1'b1, 16'h0106};
    tbl[8]  = '{1'b0, 1'b0, 16'h010A, 1'b1, 16'h0106};
    tbl[9]  = '{1'b1, 1'b1, 16'h010A, 1'b1, 16'h0106};
    tbl[10] = '{1'b1, 1'b1, 16'h010C, 1'b1, 16'h0108};
    tbl[11] = '{1'b1, 1'b1, 16'h010E, 1'b1, 16'h010A};
    tbl[12] = '{1'b1, 1'b1, 16'h0110, 1'b1, 16'h010C};
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_reset_outputs("rst");
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].rdy);
      chk($sformatf("tbl%0d_req", i), 16'(mem_req), 16'(tbl[i].req));
      chk($sformatf("tbl%0d_addr", i), mem_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 16'(instr_valid), 16'(tbl[i].vld));
      chk($sformatf("tbl%0d_pc", i), instr_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].vld ? memf(tbl[i].pc) : NOP_INSTR);
    end

    // redirect with two stale fetches outstanding
    rv_hold = 1'b1;
    repeat (6) tick(1'b1);
    chk("a_outstanding", 16'(q.size()), 16'd2);
    tick(1'b1, 1'b1, 16'h0041);
    chk("a_req_at_redirect", 16'(mem_req), 16'd0);
    rv_hold = 1'b0;
    tick(1'b1);
    chk("a_valid_n1", 16'(instr_valid), 16'd0);
    tick(1'b1);
    chk("a_valid_n2", 16'(instr_valid), 16'd0);
    for (int k = 0; k < 10 && !instr_valid; k++) tick(1'b1);
    chk("a_first_valid", 16'(instr_valid), 16'd1);
    chk("a_first_pc", instr_pc, 16'h0040);

    // redirect in the same cycle as a response
    repeat (6) tick(1'b1);
    tick(1'b1, 1'b1, 16'h0300);
    chk("b_rvalid_at_n", 16'(mem_rvalid), 16'd1);
    chk("b_req_at_n", 16'(mem_req), 16'd0);
    tick(1'b1);
    chk("b_req_n1", 16'(mem_req), 16'd1);
    chk("b_addr_n1", mem_addr, 16'h0300);
    chk("b_valid_n1", 16'(instr_valid), 16'd0);
    tick(1'b1);
    chk("b_valid_n2", 16'(instr_valid), 16'd0);
    chk("b_rvalid_n2", 16'(mem_rvalid), 16'd1);
    tick(1'b1);
    chk("b_valid_n3", 16'(instr_valid), 16'd1);
    chk("b_pc_n3", instr_pc, 16'h0300);
    chk("b_instr_n3", instr, memf(16'h0300));

    // address wrap
    begin
      logic [15:0] wa [4];
      wa = '{16'hFFFC, 16'hFFFE, 16'h0000, 16'h0002};
      tick(1'b1, 1'b1, 16'hFFFC);
      for (int i = 0; i < 4; i++) begin
        tick(1'b1);
        chk($sformatf("c_req%0d", i), 16'(mem_req), 16'd1);
        chk($sformatf("c_addr%0d", i), mem_addr, wa[i]);
      end
      repeat (4) tick(1'b1);
    end

    // backpressure right after a redirect: exactly two grants fill the credit
    begin
      int grants = 0;
      tick(1'b0, 1'b1, 16'h0200);
      for (int i = 0; i < 10; i++) begin
        tick(1'b0);
        if (mem_req && mem_gnt) grants++;
      end
      chk("d_grants", 16'(grants), 16'd2);
      chk("d_req_idle", 16'(mem_req), 16'd0);
      chk("d_head_pc", instr_pc, 16'h0200);
      repeat (8) tick(1'b1);
    end

    // random grant/response stalls, backpressure and redirects
    begin
      int p0 = pops;
      gnt_rand = 1'b1;
      rv_rand = 1'b1;
      for (int i = 0; i < 10000; i++)
        tick(1'(($urandom_range(0, 3) != 0)), 1'(($urandom_range(0, 31) == 0)), 16'($urandom));
      gnt_rand = 1'b0;
      rv_rand = 1'b0;
      checks++;
      if (pops - p0 < 500) begin
        errors++;
        $display("FAIL rand_progress: %0d instructions consumed, required >= 500", pops - p0);
      end
      repeat (6) tick(1'b1);
    end

    // asynchronous reset mid-operation
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    exp_pc = RPC;
    pend = 1'b0;
    tick(1'b1);
    chk("r_boot_req", 16'(mem_req), 16'd0);
    tick(1'b1);
    chk("r_first_req", 16'(mem_req), 16'd1);
    chk("r_first_addr", mem_addr, RPC);
    tick(1'b1);
    tick(1'b1);
    chk("r_first_valid", 16'(instr_valid), 16'd1);
    chk("r_first_pc", instr_pc, RPC);
    repeat (4) tick(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
